// File: rtl/demux12_route.sv
// 1:2 word router: steers each input word by its destination bit into one of two
// lane FIFOs, each drained independently with registered, valid-flagged read data.
module demux12_route #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned DEST_BIT = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] out0,
    output logic              valid_out0,
    output logic [DATA_W-1:0] out1,
    output logic              valid_out1,
    output logic              full0,
    output logic              full1,
    output logic              empty0,
    output logic              empty1
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q    [2][DEPTH];
    logic [DATA_W-1:0] mem_d    [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q    [2];
    logic [CNT_W-1:0]  cnt_d    [2];
    logic [DATA_W-1:0] out_q    [2];
    logic [DATA_W-1:0] out_d    [2];
    logic [1:0]        vld_q;
    logic [1:0]        vld_d;

    logic [1:0] full_c;
    logic [1:0] empty_c;
    logic [1:0] push_c;
    logic [1:0] pop_c;
    logic       dest_c;

    // Lane status, handshake and per-lane push/pop qualification
    always_comb begin
        dest_c = in_data[DEST_BIT];
        for (int l = 0; l < 2; l++) begin
            full_c[l]  = (cnt_q[l] == CNT_W'(DEPTH));
            empty_c[l] = (cnt_q[l] == '0);
        end
        // Uses pre-pop fullness: a full lane refuses a push even if popped this edge
        in_ready = ~full_c[dest_c];
        push_c   = {in_valid & dest_c & ~full_c[1], in_valid & ~dest_c & ~full_c[0]};
        pop_c    = {pop1 & ~empty_c[1], pop0 & ~empty_c[0]};
    end

    // Next-state for both lanes
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        vld_d    = pop_c;
        for (int l = 0; l < 2; l++) begin
            if (push_c[l]) begin
                mem_d[l][wr_ptr_q[l]] = in_data;
                wr_ptr_d[l]           = PTR_W'(wr_ptr_q[l] + 1'b1);
            end
            if (pop_c[l]) begin
                out_d[l]    = mem_q[l][rd_ptr_q[l]];
                rd_ptr_d[l] = PTR_W'(rd_ptr_q[l] + 1'b1);
            end
            case ({push_c[l], pop_c[l]})
                2'b10:   cnt_d[l] = CNT_W'(cnt_q[l] + 1'b1);
                2'b01:   cnt_d[l] = CNT_W'(cnt_q[l] - 1'b1);
                default: cnt_d[l] = cnt_q[l];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                cnt_q[l]    <= '0;
                out_q[l]    <= '0;
            end
            vld_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
        end
    end

    // Storage needs no reset; contents are only read behind a nonzero count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out0       = out_q[0];
    assign out1       = out_q[1];
    assign valid_out0 = vld_q[0];
    assign valid_out1 = vld_q[1];
    assign full0      = full_c[0];
    assign full1      = full_c[1];
    assign empty0     = empty_c[0];
    assign empty1     = empty_c[1];
endmodule

// File: tb/tb_demux12_route.sv
// Directed + short random bench for demux12_route with a per-lane queue scoreboard.
module tb_demux12_route;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       pop0, pop1;
    logic [9:0] out0, out1;
    logic       valid_out0, valid_out1;
    logic       full0, full1, empty0, empty1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] last0 = '0;
    logic [9:0] last1 = '0;

    demux12_route dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pop0(pop0), .pop1(pop1),
        .out0(out0), .valid_out0(valid_out0), .out1(out1), .valid_out1(valid_out1),
        .full0(full0), .full1(full1), .empty0(empty0), .empty1(empty1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags();
        chk("full0",  32'(full0),  32'(q0.size() == 4));
        chk("empty0", 32'(empty0), 32'(q0.size() == 0));
        chk("full1",  32'(full1),  32'(q1.size() == 4));
        chk("empty1", 32'(empty1), 32'(q1.size() == 0));
    endtask

    // One clock: drive, check handshake, clock, check outputs against scoreboard
    task automatic step(input logic v, input logic [9:0] d, input logic p0, input logic p1);
        logic rdy_exp, ev0, ev1, acc;
        logic [9:0] e;
        in_valid = v; in_data = d; pop0 = p0; pop1 = p1;
        #1;
        rdy_exp = d[8] ? (q1.size() < 4) : (q0.size() < 4);
        chk("in_ready", 32'(in_ready), 32'(rdy_exp));
        acc = v & rdy_exp;
        ev0 = p0 && (q0.size() != 0);
        ev1 = p1 && (q1.size() != 0);
        @(posedge clk); #1;
        chk("valid_out0", 32'(valid_out0), 32'(ev0));
        chk("valid_out1", 32'(valid_out1), 32'(ev1));
        if (valid_out0) begin
            if (q0.size() == 0) begin
                chk("out0_unexpected", 32'(out0), 32'h3ff00000);
            end else begin
                e = q0.pop_front();
                last0 = e;
                chk("out0", 32'(out0), 32'(e));
            end
        end else begin
            chk("out0_hold", 32'(out0), 32'(last0));
        end
        if (valid_out1) begin
            if (q1.size() == 0) begin
                chk("out1_unexpected", 32'(out1), 32'h3ff00000);
            end else begin
                e = q1.pop_front();
                last1 = e;
                chk("out1", 32'(out1), 32'(e));
            end
        end else begin
            chk("out1_hold", 32'(out1), 32'(last1));
        end
        if (acc) begin
            if (d[8]) q1.push_back(d);
            else      q0.push_back(d);
        end
        chk_flags();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; pop0 = 1'b0; pop1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out0", 32'(out0), 32'h0);
        chk("rst_out1", 32'(out1), 32'h0);
        chk("rst_vld0", 32'(valid_out0), 32'h0);
        chk("rst_vld1", 32'(valid_out1), 32'h0);
        chk_flags();
        reset = 1'b0;

        // Reset mid-stream with three words queued in lane0
        step(1'b1, 10'h011, 1'b0, 1'b0);
        step(1'b1, 10'h022, 1'b0, 1'b0);
        step(1'b1, 10'h033, 1'b1, 1'b0);
        step(1'b1, 10'h044, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 10'h055;
        #2 reset = 1'b1;
        #1;
        q0.delete(); q1.delete(); last0 = '0; last1 = '0;
        chk("midrst_empty0", 32'(empty0), 32'h1);
        chk("midrst_vld0",   32'(valid_out0), 32'h0);
        chk("midrst_out0",   32'(out0), 32'h0);
        chk("midrst_ready",  32'(in_ready), 32'h1);
        #1 reset = 1'b0;
        step(1'b0, 10'h000, 1'b1, 1'b1);

        // Route by bit 8, then pop each lane
        step(1'b1, 10'h155, 1'b0, 1'b0);
        step(1'b1, 10'h0AA, 1'b0, 1'b0);
        step(1'b0, 10'h000, 1'b0, 1'b1);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b0, 10'h000, 1'b0, 1'b0);

        // Fill lane0, fifth word waits for a pop
        for (int i = 1; i <= 4; i++) step(1'b1, 10'(i), 1'b0, 1'b0);
        step(1'b1, 10'h005, 1'b0, 1'b0);
        step(1'b1, 10'h005, 1'b1, 1'b0);
        step(1'b1, 10'h005, 1'b0, 1'b0);

        // Lane0 full: lane1 keeps flowing while the lane0 word stalls
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 10'h0E0, 1'b0, 1'b0);
            step(1'b1, 10'(10'h140 + i), 1'b0, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 10'h000, 1'b1, 1'b1);

        // Lane1 at count 2, simultaneous push+pop across pointer wrap
        step(1'b1, 10'h1A0, 1'b0, 1'b0);
        step(1'b1, 10'h1A1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 10'(10'h1B0 + i), 1'b0, 1'b1);
        chk("lane1_cnt2", 32'(q1.size()), 32'd2);
        step(1'b0, 10'h100, 1'b0, 1'b1);
        step(1'b0, 10'h100, 1'b0, 1'b1);

        // pop0 on empty lane0, then confirm pointers did not move
        for (int i = 0; i < 3; i++) step(1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b1, 10'h077, 1'b1, 1'b0);
        step(1'b0, 10'h000, 1'b1, 1'b0);

        // Short random mix
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) step(1'b0, 10'h000, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
